// File: rtl/event_sequencer.sv
// Baseline / trigger / peak sequencer that drives the useful_event comparator and counts useful events.
// Define EVENT_HOLDOFF_EN to add a post-report holdoff window of HOLDOFF valid samples.
module event_sequencer #(
   parameter int BASE_LOG2    = 4,
   parameter int TRIG_DELTA   = 500,
   parameter int FALL_DELTA   = 1000,
   parameter int PEAK_TIMEOUT = 64,
   parameter int CHECK_CYCLES = 2,
   parameter int HOLDOFF      = 32
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic        stop,
   input  logic        sample_valid,
   input  logic [19:0] sample_data,
   input  logic        useful_event_out,
   output logic        useful_event_enable,
   output logic [19:0] baseline_value,
   output logic [19:0] current_maximum_value,
   output logic        event_done,
   output logic        event_useful,
   output logic [15:0] event_count,
   output logic        busy
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_BASELINE = 3'd1;
   localparam logic [2:0] S_ARMED    = 3'd2;
   localparam logic [2:0] S_PEAK     = 3'd3;
   localparam logic [2:0] S_CHECK    = 3'd4;
   localparam logic [2:0] S_REPORT   = 3'd5;
`ifdef EVENT_HOLDOFF_EN
   localparam logic [2:0] S_HOLDOFF  = 3'd6;
`endif

   localparam int ACC_W = 20 + BASE_LOG2;
   // One shared counter serves every phase, so it is sized for the longest of them.
   localparam int CNT_M1 = ((1 << BASE_LOG2) > PEAK_TIMEOUT) ? (1 << BASE_LOG2) : PEAK_TIMEOUT;
   localparam int CNT_M2 = (CNT_M1 > HOLDOFF) ? CNT_M1 : HOLDOFF;
   localparam int CNT_M3 = (CNT_M2 > CHECK_CYCLES) ? CNT_M2 : CHECK_CYCLES;
   localparam int CNT_W  = $clog2(CNT_M3 + 1);

   localparam logic [CNT_W-1:0] BASE_LAST  = CNT_W'((1 << BASE_LOG2) - 1);
   localparam logic [CNT_W-1:0] PEAK_LAST  = CNT_W'(PEAK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(CHECK_CYCLES - 1);
`ifdef EVENT_HOLDOFF_EN
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);
`endif

   function automatic logic [19:0] clamp20(input logic [20:0] v);
      return v[20] ? 20'hFFFFF : v[19:0];
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [2:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [19:0]      r_base;
   logic [19:0]      r_max;
   logic [15:0]      r_count;
   logic             r_stop_seen;
   logic             r_verdict;

   logic [ACC_W-1:0] w_acc_sum;
   logic [19:0]      w_level;
   logic             w_trig;
   logic             w_fall;
   logic             w_rise;

   assign w_acc_sum = r_acc + ACC_W'(sample_data);
   // Level is formed in 21 bits so a baseline near full scale clamps instead of wrapping low.
   assign w_level   = clamp20({1'b0, r_base} + 21'(TRIG_DELTA));
   assign w_trig    = sample_valid && (sample_data > w_level);
   assign w_fall    = ({1'b0, sample_data} + 21'(FALL_DELTA)) < {1'b0, r_max};
   assign w_rise    = sample_data > r_max;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_base      <= '0;
         r_max       <= '0;
         r_count     <= '0;
         r_stop_seen <= 1'b0;
         r_verdict   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !stop) begin
                  r_state     <= S_BASELINE;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_count     <= '0;
                  r_stop_seen <= 1'b0;
               end
            end
            S_BASELINE: begin
               if (stop) begin
                  r_state <= S_IDLE;
               end else if (sample_valid) begin
                  r_acc <= w_acc_sum;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == BASE_LAST) begin
                     r_base  <= w_acc_sum[ACC_W-1:BASE_LOG2];
                     r_state <= S_ARMED;
                  end
               end
            end
            S_ARMED: begin
               if (stop) begin
                  r_state <= S_IDLE;
               end else if (w_trig) begin
                  r_max   <= sample_data;
                  r_cnt   <= '0;
                  r_state <= S_PEAK;
               end
            end
            S_PEAK: begin
               if (stop) r_stop_seen <= 1'b1;
               if (sample_valid) begin
                  if (w_rise) r_max <= sample_data;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_fall || (r_cnt == PEAK_LAST)) begin
                     r_cnt   <= '0;
                     r_state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               // Enable has been high since entry; the last cycle sees the comparator's registered verdict.
               if (stop) r_stop_seen <= 1'b1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CHECK_LAST) begin
                  r_verdict <= useful_event_out;
                  r_state   <= S_REPORT;
               end
            end
            S_REPORT: begin
               if (r_verdict) r_count <= sat_inc16(r_count);
               r_cnt <= '0;
               if (r_stop_seen || stop) begin
                  r_stop_seen <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
`ifdef EVENT_HOLDOFF_EN
                  r_state <= S_HOLDOFF;
`else
                  r_state <= S_ARMED;
`endif
               end
            end
`ifdef EVENT_HOLDOFF_EN
            S_HOLDOFF: begin
               if (stop) begin
                  r_state <= S_IDLE;
               end else if (sample_valid) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == HOLD_LAST) r_state <= S_ARMED;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy                  = (r_state != S_IDLE);
   assign useful_event_enable   = (r_state == S_CHECK);
   assign event_done            = (r_state == S_REPORT);
   assign event_useful          = event_done && r_verdict;
   assign baseline_value        = r_base;
   assign current_maximum_value = r_max;
   assign event_count           = r_count;

endmodule
